// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: two request channels (operands in,
// ready out) and two response channels (result/flags out, ready in).
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int W   = 16,
    parameter int SHW = 4
);
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [SHW-1:0] req0_shift, req1_shift;
    logic [3:0]     req0_op, req1_op;

    logic           rsp0_valid, rsp1_valid;
    logic           rsp0_ready, rsp1_ready;
    logic [W-1:0]   rsp0_res, rsp1_res;
    logic [3:0]     rsp0_szcv, rsp1_szcv;
    logic           rsp0_err, rsp1_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_shift, req0_op,
        output req1_valid, req1_a, req1_b, req1_shift, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_res, rsp0_szcv, rsp0_err,
        input  rsp1_valid, rsp1_res, rsp1_szcv, rsp1_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_shift, req0_op,
        input  req1_valid, req1_a, req1_b, req1_shift, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_res, rsp0_szcv, rsp0_err,
        output rsp1_valid, rsp1_res, rsp1_szcv, rsp1_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one ISSUE cycle driving the ALU from latched
// operands, then the result is held on the owner's response channel until
// consumed. Optional macro ALU_ARB_OPFILTER_EN rejects opcodes 0111 and 11xx
// (no ALU drive, zero result, err=1) without changing timing.
module alu_arbiter #(
    parameter int W   = 16,
    parameter int SHW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_arbiter_if.slave   bus,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [SHW-1:0] alu_shift_d,
    output logic [3:0]     alu_op,
    input  logic [W-1:0]   alu_res,
    input  logic [3:0]     alu_szcv
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [SHW-1:0] shift;
        logic [3:0]     op;
    } req_t;

    state_t       state, state_nx;
    req_t [1:0]   req_in;
    req_t         cur;
    logic [1:0]   req_valid, rsp_ready, ready;
    logic         any_valid, gnt, owner, last_grant, drive, legal;
    logic         rsp_vld, rsp_err;
    logic [W-1:0] rsp_res;
    logic [3:0]   rsp_szcv;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign req_in[0] = {bus.req0_a, bus.req0_b, bus.req0_shift, bus.req0_op};
    assign req_in[1] = {bus.req1_a, bus.req1_b, bus.req1_shift, bus.req1_op};

    // Lone requester wins; on a tie the one that did not win last time.
    assign any_valid = |req_valid;
    assign gnt       = (&req_valid) ? ~last_grant : req_valid[1];

`ifdef ALU_ARB_OPFILTER_EN
    assign legal = !((cur.op == 4'b0111) || (cur.op[3:2] == 2'b11));
`else
    assign legal = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state, request ready and ALU drive enable.
    always_comb begin
        state_nx = state;
        ready    = 2'b00;
        drive    = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    ready[gnt] = 1'b1;
                    state_nx   = ISSUE;
                end
            end
            ISSUE: begin
                drive    = legal;
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready[owner]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, grant history and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_vld    <= 1'b0;
            rsp_res    <= '0;
            rsp_szcv   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        cur        <= req_in[gnt];
                        owner      <= gnt;
                        last_grant <= gnt;
                    end
                end
                ISSUE: begin
                    rsp_vld  <= 1'b1;
                    rsp_res  <= legal ? alu_res : '0;
                    rsp_szcv <= legal ? alu_szcv : 4'b0000;
                    rsp_err  <= ~legal;
                end
                RESP: begin
                    if (rsp_ready[owner]) rsp_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ALU sees zeros (ADD 0+0) except during a legal ISSUE cycle.
    assign {alu_a, alu_b, alu_shift_d, alu_op} = drive ? cur : '0;

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.rsp0_valid = rsp_vld & ~owner;
    assign bus.rsp1_valid = rsp_vld & owner;
    assign bus.rsp0_res   = rsp_res;
    assign bus.rsp1_res   = rsp_res;
    assign bus.rsp0_szcv  = rsp_szcv;
    assign bus.rsp1_szcv  = rsp_szcv;
    assign bus.rsp0_err   = rsp_err;
    assign bus.rsp1_err   = rsp_err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by random traffic, all
// checked each cycle against a transaction-level model (one op outstanding,
// response visible two cycles after accept, freed the cycle after it is
// consumed). A behavioural ALU stands in for the real alu_shifter.
module tb_alu_arbiter;
    localparam int W   = 16;
    localparam int SHW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   alu_a, alu_b, alu_res;
    logic [SHW-1:0] alu_shift_d;
    logic [3:0]     alu_op, alu_szcv;

    alu_arbiter_if #(.W(W), .SHW(SHW)) bus ();

    alu_arbiter #(.W(W), .SHW(SHW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_shift_d (alu_shift_d),
        .alu_op      (alu_op),
        .alu_res     (alu_res),
        .alu_szcv    (alu_szcv)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {S,Z,C,V,res}.
    function automatic logic [W+3:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [SHW-1:0] sh, input logic [3:0] op);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         c, v;
        t = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd1: begin
                t = {1'b0, a} - {1'b0, b}; r = t[W-1:0]; c = t[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            default: r = ~(a ^ b);
        endcase
        return {r[W-1], (r == '0), c, v, r};
    endfunction

    assign {alu_szcv, alu_res} = alu_fn(alu_a, alu_b, alu_shift_d, alu_op);

    function automatic bit illegal(input logic [3:0] op);
`ifdef ALU_ARB_OPFILTER_EN
        return (op == 4'b0111) || (op >= 4'b1100);
`else
        return 1'b0;
`endif
    endfunction

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference model state.
    bit             busy = 0;
    int             age = 0, own_m = 0, last_m = 1, win = -1;
    bit             con = 0;
    logic [W-1:0]   m_a, m_b, exp_res;
    logic [SHW-1:0] m_sh;
    logic [3:0]     m_op, exp_szcv;
    logic           exp_err;

    // Negedge half: compare every DUT output with the model, note handshakes.
    task automatic cyc_a();
        logic [2*W+SHW+3:0] exp_alu;
        @(negedge clk);
        win = -1;
        if (!busy) begin
            if (bus.req0_valid && bus.req1_valid) win = (last_m == 0) ? 1 : 0;
            else if (bus.req0_valid)              win = 0;
            else if (bus.req1_valid)              win = 1;
        end
        chk("req0_ready", bus.req0_ready, win == 0);
        chk("req1_ready", bus.req1_ready, win == 1);
        chk("rsp0_valid", bus.rsp0_valid, busy && age >= 2 && own_m == 0);
        chk("rsp1_valid", bus.rsp1_valid, busy && age >= 2 && own_m == 1);
        if (busy && age >= 2) begin
            if (own_m == 0) begin
                chk("rsp0_res", bus.rsp0_res, exp_res);
                chk("rsp0_szcv", bus.rsp0_szcv, exp_szcv);
                chk("rsp0_err", bus.rsp0_err, exp_err);
            end else begin
                chk("rsp1_res", bus.rsp1_res, exp_res);
                chk("rsp1_szcv", bus.rsp1_szcv, exp_szcv);
                chk("rsp1_err", bus.rsp1_err, exp_err);
            end
        end
        exp_alu = '0;
        if (busy && age == 1 && !illegal(m_op)) exp_alu = {m_a, m_b, m_sh, m_op};
        chk("alu_bus", {alu_a, alu_b, alu_shift_d, alu_op}, exp_alu);
        con = busy && age >= 2 && ((own_m == 0) ? bus.rsp0_ready : bus.rsp1_ready);
        if (win == 0) begin
            m_a = bus.req0_a; m_b = bus.req0_b; m_sh = bus.req0_shift; m_op = bus.req0_op;
        end else if (win == 1) begin
            m_a = bus.req1_a; m_b = bus.req1_b; m_sh = bus.req1_shift; m_op = bus.req1_op;
        end
    endtask

    // Posedge half: advance the model.
    task automatic cyc_b();
        @(posedge clk);
        if (con) busy = 0;
        else if (busy) age++;
        if (win >= 0) begin
            busy = 1; age = 1; own_m = win; last_m = win;
            if (illegal(m_op)) begin
                exp_res = '0; exp_szcv = '0; exp_err = 1'b1;
            end else begin
                {exp_szcv, exp_res} = alu_fn(m_a, m_b, m_sh, m_op);
                exp_err = 1'b0;
            end
        end
    endtask

    task automatic tick();
        cyc_a(); cyc_b(); #1;
    endtask

    task automatic set0(input bit v, input int a, input int b, input int sh, input int op);
        bus.req0_valid = v; bus.req0_a = W'(a); bus.req0_b = W'(b);
        bus.req0_shift = SHW'(sh); bus.req0_op = 4'(op);
    endtask

    task automatic set1(input bit v, input int a, input int b, input int sh, input int op);
        bus.req1_valid = v; bus.req1_a = W'(a); bus.req1_b = W'(b);
        bus.req1_shift = SHW'(sh); bus.req1_op = 4'(op);
    endtask

    // Asynchronous reset asserted mid-cycle (called right after cyc_a).
    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        chk("rst_alu_bus", {alu_a, alu_b, alu_shift_d, alu_op}, '0);
        busy = 0; last_m = 1; win = -1; con = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_req(input int n);
        bit v;
        v = ($urandom_range(0, 3) != 0);
        if (n == 0) set0(v, $urandom, $urandom, $urandom_range(0, 15), $urandom_range(0, 15));
        else        set1(v, $urandom, $urandom, $urandom_range(0, 15), $urandom_range(0, 15));
    endtask

    initial begin
        int k;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        chk("reset_rsp_data", {bus.rsp0_res, bus.rsp0_szcv, bus.rsp0_err}, '0);
        chk("reset_alu_bus", {alu_a, alu_b, alu_shift_d, alu_op}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: lone ADD 3+4.
        set0(1, 3, 4, 0, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        tick();
        cyc_a();
        chk("t1_res", bus.rsp0_res, 16'd7);
        chk("t1_z", bus.rsp0_szcv[2], 1'b0);
        chk("t1_rsp1_idle", bus.rsp1_valid, 1'b0);
        cyc_b(); #1;
        bus.rsp0_ready = 1'b1;
        tick();

        // 2: SUB 5-5 sets Z.
        set0(1, 5, 5, 0, 1);
        tick();
        set0(0, 0, 0, 0, 0);
        tick();
        cyc_a();
        chk("t2_res", bus.rsp0_res, 16'd0);
        chk("t2_z", bus.rsp0_szcv[2], 1'b1);
        cyc_b(); #1;

        // 3: both valid from reset, held: grants alternate 0,1,0,1.
        cyc_a();
        reset_mid();
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set0(1, 10, 20, 1, 0);
        set1(1, 100, 7, 2, 1);
        k = 0;
        for (int i = 0; i < 24; i++) begin
            cyc_a();
            if (bus.req0_ready || bus.req1_ready) begin
                chk("t3_order", bus.req1_ready, k % 2);
                k++;
            end
            cyc_b(); #1;
        end
        chk("t3_grants", k, 8);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (3) tick();

        // 4: back-pressure in RESP for 5 cycles with req1 pending.
        bus.rsp0_ready = 1'b0;
        set0(1, 16'h7fff, 1, 0, 0);
        set1(1, 9, 3, 0, 4);
        tick();
        set0(0, 0, 0, 0, 0);
        repeat (6) tick();
        bus.rsp0_ready = 1'b1;
        tick();
        cyc_a();
        chk("t4_gnt1", bus.req1_ready, 1'b1);
        cyc_b(); #1;
        set1(0, 0, 0, 0, 0);
        repeat (3) tick();

        // 5: reset during ISSUE, then tie goes to req0; reset during RESP.
        set0(1, 1, 2, 0, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        cyc_a();
        reset_mid();
        set0(1, 4, 4, 0, 2);
        set1(1, 8, 8, 0, 3);
        cyc_a();
        chk("t5_first", bus.req0_ready, 1'b1);
        cyc_b(); #1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (3) tick();
        bus.rsp1_ready = 1'b0;
        set1(1, 2, 3, 0, 0);
        tick();
        set1(0, 0, 0, 0, 0);
        tick();
        cyc_a();
        reset_mid();
        bus.rsp1_ready = 1'b1;

        // 6: opcode 0111.
        set0(1, 9, 2, 0, 7);
        tick();
        set0(0, 0, 0, 0, 0);
        cyc_a();
`ifdef ALU_ARB_OPFILTER_EN
        chk("t6_alu_op", alu_op, 4'd0);
`else
        chk("t6_alu_op", alu_op, 4'd7);
`endif
        cyc_b(); #1;
        cyc_a();
`ifdef ALU_ARB_OPFILTER_EN
        chk("t6_err", bus.rsp0_err, 1'b1);
        chk("t6_res", bus.rsp0_res, 16'd0);
`else
        chk("t6_err", bus.rsp0_err, 1'b0);
`endif
        cyc_b(); #1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc_a(); cyc_b(); #1;
            if (win == 0 || !bus.req0_valid) rand_req(0);
            if (win == 1 || !bus.req1_valid) rand_req(1);
            bus.rsp0_ready = ($urandom_range(0, 2) != 0);
            bus.rsp1_ready = ($urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
